// File: rtl/arm_sequencer_if.sv
// Bus between the sequencer and its surroundings (instruction memory, datapath flags, ALU).
//   imem_data/imem_valid : fetched instruction word and its valid strobe
//   zero_flag            : datapath Rd==0 flag, meaningful in EXEC1 of a branch
//   resume               : request to leave HALT
//   imem_addr            : instruction address (the PC)
//   inst                 : instruction register, decoded by the ALU
//   state                : one-hot FETCH/EXEC1/EXEC2, all-zero for HALT
//   halted               : high while in HALT
//   retired              : completed-instruction count
// modport slave is the sequencer side, modport master is the environment side.
interface arm_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic [15:0]     imem_data;
  logic            imem_valid;
  logic            zero_flag;
  logic            resume;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     inst;
  logic [2:0]      state;
  logic            halted;
  logic [15:0]     retired;

  modport slave (
    input  imem_data,
    input  imem_valid,
    input  zero_flag,
    input  resume,
    output imem_addr,
    output inst,
    output state,
    output halted,
    output retired
  );

  modport master (
    output imem_data,
    output imem_valid,
    output zero_flag,
    output resume,
    input  imem_addr,
    input  inst,
    input  state,
    input  halted,
    input  retired
  );
endinterface

// File: rtl/arm_sequencer.sv
// Control sequencer for the non-pipelined Harvard CPU. Fetches an instruction into the IR,
// steps the one-hot FETCH/EXEC1/EXEC2 state for the ALU, and owns the PC (increment, jump,
// zero-conditional relative branch), HALT/resume and the retired-instruction counter.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : arm_sequencer_if.slave (imem_data/imem_valid/zero_flag/resume in;
//         imem_addr/inst/state/halted/retired out)
// PC_W must be between 1 and 16.
module arm_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  arm_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StHalt  = 3'b000,
    StFetch = 3'b001,
    StExec1 = 3'b010,
    StExec2 = 3'b100
  } state_e;

  localparam logic [3:0] OpJump   = 4'b0001;
  localparam logic [3:0] OpBranch = 4'b0100;
  localparam logic [3:0] OpHalt   = 4'b0101;
  localparam logic [3:0] OpLdr    = 4'b1110;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     inst_q;
  logic [15:0]     retired_q;

  logic [3:0]      opcode;
  logic [PC_W-1:0] branch_off;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;

  always_comb begin
    opcode        = inst_q[15:12];
    // Sign-extend the 8-bit offset, then truncate to PC width so arithmetic wraps mod 2^PC_W.
    branch_off    = PC_W'({{8{inst_q[7]}}, inst_q[7:0]});
    branch_target = pc_q + branch_off;
    jump_target   = inst_q[PC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (bus.imem_valid) begin
            inst_q  <= bus.imem_data;
            pc_q    <= pc_q + PC_W'(1);
            state_q <= StExec1;
          end
        end
        StExec1: begin
          if (opcode == OpLdr) begin
            state_q <= StExec2;
          end else begin
            // Every non-ldr instruction, halt included, completes here.
            retired_q <= retired_q + 16'd1;
            state_q   <= (opcode == OpHalt) ? StHalt : StFetch;
            if (opcode == OpJump) begin
              pc_q <= jump_target;
            end else if ((opcode == OpBranch) && bus.zero_flag) begin
              pc_q <= branch_target;
            end
          end
        end
        StExec2: begin
          retired_q <= retired_q + 16'd1;
          state_q   <= StFetch;
        end
        StHalt: begin
          if (bus.resume) begin
            state_q <= StFetch;
          end
        end
        // Any non-one-hot encoding recovers to FETCH.
        default: state_q <= StFetch;
      endcase
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.inst      = inst_q;
  assign bus.state     = state_q;
  assign bus.halted    = (state_q == StHalt);
  assign bus.retired   = retired_q;

endmodule

// File: doc/arm_sequencer.md
Name: arm_sequencer

Overview:
- Control stage directly upstream of the 16-bit ALU in the non-pipelined Harvard CPU.
- Fetches a 16-bit instruction from instruction memory and holds it in the instruction register (IR).
- Drives the one-hot `state` bus (fetch/exec1/exec2) and `inst` that the ALU decodes for wen/ldr/reg_mux.
- Owns the program counter, jumps, conditional branches, halt, and a retired-instruction counter.

Parameters:
- PC_W, 8, program counter / instruction address width (bits).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_data  input  16  instruction word at imem_addr.
- imem_valid  input  1  imem_data valid this cycle.
- zero_flag  input  1  datapath flag: Rd data == 0, sampled in EXEC1.
- resume  input  1  leave HALT.
- imem_addr  output  PC_W  equals pc.
- inst  output  16  IR contents, to ALU.
- state  output  3  one-hot: [0]=FETCH, [1]=EXEC1, [2]=EXEC2; 3'b000=HALT.
- halted  output  1  high while in HALT.
- retired  output  16  count of completed instructions.

Behaviour:
- Reset (rst=1 at a clock edge): state=3'b001, pc=RESET_PC, inst=16'h0000, retired=0, halted=0.
- Reset mid-instruction aborts the instruction. Nothing is retired and the PC is not updated.
- All outputs are registered, except that halted is decoded from the state register.
- FETCH:
  - If imem_valid=1: inst<=imem_data, pc<=pc+1 (mod 2^PC_W), go to EXEC1.
  - Otherwise hold all registers and stay in FETCH (unbounded stall).
- EXEC1 decode uses inst[15:12]:
  - 1110 (ldr): go to EXEC2; pc unchanged.
  - 0001 (jump): pc<=inst[PC_W-1:0]; go to FETCH.
  - 0100 (branch if zero): if zero_flag=1, pc<=pc+sign-extended inst[7:0] (mod 2^PC_W); go to FETCH. Otherwise go to FETCH with pc unchanged.
  - 0101 (halt): go to HALT.
  - Any other encoding (ALU ops 1xxx except 1110, reg_mux ops 001x, nop 0000, reserved): go to FETCH.
- Branch offset is relative to the already-incremented pc, i.e. the branch address + 1.
- EXEC2: always go to FETCH.
- HALT:
  - state=3'b000, halted=1, pc and inst hold.
  - resume=1 at an edge goes to FETCH; rst has priority over resume.
- Retire timing: retired increments by 1 (wrapping 16'hFFFF->0) on the last exec cycle of each instruction. That is EXEC2 for ldr, and EXEC1 for all others, including halt.
- Latency:
  - 2 cycles per instruction with a ready memory.
  - 3 cycles for ldr.
  - Each imem_valid=0 cycle adds one cycle.
- state is always exactly one of 001/010/100/000. Any other value is illegal; the implementation recovers to FETCH on the next edge.
- inst changes only on a FETCH edge with imem_valid=1. It is stable throughout EXEC1/EXEC2, as the ALU requires.
- pc wrap: at pc=2^PC_W-1, FETCH sets pc=0. Branch arithmetic also wraps.
- imem_valid is ignored outside FETCH, and zero_flag is ignored outside EXEC1 for opcode 0100.

Test Plan:
- Reset then imem_valid=1 with data 16'h8123 (add) → state 001→010→001; inst=16'h8123; pc 0→1; retired=1 after 2 cycles.
- ldr 16'hE045 at pc=3 → state 001→010→100→001; retired increments once, on the EXEC2 edge; pc=4.
- Jump 16'h1037 → pc=8'h37 after EXEC1. Branch 16'h40FC at pc=10 with zero_flag=1 → pc=11-4=7; with zero_flag=0 → pc=11.
- imem_valid held low 5 cycles in FETCH → state=001, pc and inst unchanged; then valid → normal EXEC1.
- Halt 16'h5000 → state=000, halted=1 for 10 cycles; resume=1 → FETCH, pc=next address. resume and rst asserted together → reset values.
- pc=8'hFF fetch → pc=0. rst asserted during EXEC2 of ldr → state=001, pc=0, retired=0.
